// File: rtl/axi_r_arbiter.sv
// Two-requester read arbiter (ifetch m0, load m1) in front of a single AXI read burster.
// Define AXI_R_ARB_FIXED_PRIO_EN to let m1 always win ties instead of round-robin.

`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module axi_r_arbiter #(
    parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
    parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
    parameter int ID_WIDTH   = `AXI_ID_WIDTH
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [3:0]            m0_len,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic                  m0_rlast,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [3:0]            m1_len,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic                  m1_rlast,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ren,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [3:0]            arlen,
    output logic [2:0]            arsize,
    output logic [ID_WIDTH-1:0]   arid,
    input  logic                  raddr_ok,
    input  logic                  rdata_ok,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        ADDR = 3'b010,
        DATA = 3'b100
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic                    owner_r;
    logic [3:0]              beat_r;
    logic [ADDR_WIDTH-1:0]   araddr_r;
    logic [3:0]              arlen_r;
    logic [2:0]              arsize_r;
    logic [ID_WIDTH-1:0]     arid_r;
    logic                    winner_s;
    logic                    take_s;
    logic                    beat_s;
    logic                    last_s;

`ifndef AXI_R_ARB_FIXED_PRIO_EN
    logic                    last_grant_r;
`endif

    assign araddr = araddr_r;
    assign arlen  = arlen_r;
    assign arsize = arsize_r;
    assign arid   = arid_r;

    // Winner selection: a lone requester wins outright; ties resolved by priority mode.
    always_comb begin
        winner_s = 1'b0;
        if (m0_req && m1_req) begin
`ifdef AXI_R_ARB_FIXED_PRIO_EN
            winner_s = 1'b1;
`else
            winner_s = ~last_grant_r;
`endif
        end else if (m1_req) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Next-state and handshake outputs; everything is forced quiet while reset is held.
    always_comb begin
        state_s   = state_r;
        take_s    = 1'b0;
        beat_s    = 1'b0;
        last_s    = 1'b0;
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        ren       = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m0_rlast  = 1'b0;
        m1_rlast  = 1'b0;
        rdata     = '0;
        if (!ARESETn) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if ((m0_req || m1_req) && raddr_ok) begin
                        take_s  = 1'b1;
                        m0_gnt  = ~winner_s;
                        m1_gnt  = winner_s;
                        state_s = ADDR;
                    end else begin
                        state_s = IDLE;
                    end
                end
                ADDR: begin
                    ren = 1'b1;
                    if (raddr_ok) begin
                        state_s = DATA;
                    end else begin
                        state_s = ADDR;
                    end
                end
                DATA: begin
                    if (rdata_ok) begin
                        beat_s    = 1'b1;
                        last_s    = (beat_r == arlen_r);
                        m0_rvalid = ~owner_r;
                        m1_rvalid = owner_r;
                        m0_rlast  = ~owner_r & last_s;
                        m1_rlast  = owner_r & last_s;
                        rdata     = sram_rdata;
                        state_s   = last_s ? IDLE : DATA;
                    end else begin
                        state_s = DATA;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Burst context captured at grant, beat counter advanced per accepted beat.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            owner_r  <= 1'b0;
            beat_r   <= 4'd0;
            araddr_r <= '0;
            arlen_r  <= 4'd0;
            arsize_r <= 3'd0;
            arid_r   <= '0;
        end else if (take_s) begin
            owner_r  <= winner_s;
            beat_r   <= 4'd0;
            araddr_r <= winner_s ? m1_addr : m0_addr;
            arlen_r  <= winner_s ? m1_len : m0_len;
            arsize_r <= 3'b010;
            arid_r   <= ID_WIDTH'(winner_s);
        end else if (beat_s) begin
            beat_r <= last_s ? 4'd0 : beat_r + 4'd1;
        end else begin
            beat_r <= beat_r;
        end
    end

`ifndef AXI_R_ARB_FIXED_PRIO_EN
    // Remember the last winner; reset value makes m0 the favourite after reset.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            last_grant_r <= 1'b1;
        end else if (take_s) begin
            last_grant_r <= winner_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

endmodule

// File: tb/tb_axi_r_arbiter.sv
// Scoreboard bench for axi_r_arbiter: expected beats are queued when driven and checked as rvalid appears.
`timescale 1ns/1ps

module tb_axi_r_arbiter;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr;
    logic [3:0]  m0_len, m1_len;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
    logic [31:0] rdata;
    logic        ren;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [3:0]  arid;
    logic        raddr_ok, rdata_ok;
    logic [31:0] sram_rdata;

    beat_t sb[$];
    int    vectors = 0;
    int    miscompares = 0;

    axi_r_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_len(m0_len), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_len(m1_len), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast),
        .rdata(rdata), .ren(ren), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arid(arid),
        .raddr_ok(raddr_ok), .rdata_ok(rdata_ok), .sram_rdata(sram_rdata)
    );

    always #5 ACLK = ~ACLK;

    // Beat monitor: every rvalid must match the head of the scoreboard.
    always @(negedge ACLK) begin
        beat_t e;
        if (m0_rvalid || m1_rvalid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL beat_unexpected: got m0_rvalid=%b m1_rvalid=%b rdata=%h, expected no beat",
                         m0_rvalid, m1_rvalid, rdata);
            end else begin
                e = sb.pop_front();
                if ({m1_rvalid, m0_rvalid, m1_rlast, m0_rlast, rdata} !==
                    {e.owner, ~e.owner, e.owner & e.last, ~e.owner & e.last, e.data}) begin
                    miscompares++;
                    $display("FAIL beat: got v1=%b v0=%b l1=%b l0=%b d=%h, expected v1=%b v0=%b l1=%b l0=%b d=%h",
                             m1_rvalid, m0_rvalid, m1_rlast, m0_rlast, rdata,
                             e.owner, ~e.owner, e.owner & e.last, ~e.owner & e.last, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        repeat (3) tick();
        sb.delete();
        ARESETn = 1'b1;
    endtask

    task automatic await_any_gnt(input int budget, output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < budget; i++) begin
            @(negedge ACLK);
            if (m0_gnt || m1_gnt) begin
                g = {m1_gnt, m0_gnt};
                break;
            end
            tick();
        end
    endtask

    // Feeds len+1 beats from DATA state, with one idle cycle after the first beat.
    task automatic drive_beats(input logic who, input logic [3:0] len, input logic [31:0] base);
        for (int i = 0; i <= int'(len); i++) begin
            if (i == 1) begin
                rdata_ok = 1'b0;
                @(negedge ACLK);
                tick();
            end
            rdata_ok   = 1'b1;
            sram_rdata = base + 32'(i);
            sb.push_back('{who, base + 32'(i), (i == int'(len))});
            @(negedge ACLK);
            tick();
        end
        rdata_ok = 1'b0;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; raddr_ok = 1'b1; rdata_ok = 1'b1;
        m0_addr = 32'h55; m1_addr = 32'h66; m0_len = 4'd1; m1_len = 4'd1; sram_rdata = 32'h1234;
        repeat (3) tick();
        @(negedge ACLK);
        vectors++;
        if ({m0_gnt, m1_gnt, ren, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast} !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, expected 0000000",
                     {m0_gnt, m1_gnt, ren, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast});
        end
        vectors++;
        if ({araddr, arlen, arsize, arid, rdata} !== 75'd0) begin
            miscompares++;
            $display("FAIL reset_data: got araddr=%h arlen=%h arsize=%h arid=%h rdata=%h, expected all 0",
                     araddr, arlen, arsize, arid, rdata);
        end
        tick();
        m0_req = 1'b0; m1_req = 1'b0; rdata_ok = 1'b0;
        do_reset();
    endtask

    task automatic test_single_m0();
        logic [1:0] g;
        m0_req = 1'b1; m0_addr = 32'h100; m0_len = 4'd3; raddr_ok = 1'b1;
        await_any_gnt(1, g);
        vectors++;
        if ({g, ren} !== 3'b010) begin
            miscompares++;
            $display("FAIL m0_grant: got gnt=%b ren=%b, expected gnt=01 ren=0", g, ren);
        end
        tick();
        m0_req = 1'b0;
        @(negedge ACLK);
        vectors++;
        if ({ren, araddr, arlen, arsize, arid} !== {1'b1, 32'h100, 4'd3, 3'b010, 4'd0}) begin
            miscompares++;
            $display("FAIL m0_addr_phase: got ren=%b araddr=%h arlen=%0d arsize=%0d arid=%0d, expected 1 100 3 2 0",
                     ren, araddr, arlen, arsize, arid);
        end
        tick();
        drive_beats(1'b0, 4'd3, 32'hA000_0000);
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL m0_beats_left: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] g;
        logic       last_w = 1'b1;
        logic       exp_w;
        do_reset();
        m0_addr = 32'h200; m0_len = 4'd1; m1_addr = 32'h300; m1_len = 4'd2;
        m0_req = 1'b1; m1_req = 1'b1; raddr_ok = 1'b1;
        for (int r = 0; r < 4; r++) begin
`ifdef AXI_R_ARB_FIXED_PRIO_EN
            exp_w = 1'b1;
`else
            exp_w = ~last_w;
`endif
            await_any_gnt(1, g);
            vectors++;
            if (g !== {exp_w, ~exp_w}) begin
                miscompares++;
                $display("FAIL rr_grant round %0d: got gnt=%b, expected %b", r, g, {exp_w, ~exp_w});
            end
            tick();
            if (exp_w) m1_req = 1'b0; else m0_req = 1'b0;
            @(negedge ACLK);
            vectors++;
            if ({ren, arid} !== {1'b1, 3'd0, exp_w}) begin
                miscompares++;
                $display("FAIL rr_addr round %0d: got ren=%b arid=%0d, expected 1 %0d", r, ren, arid, exp_w);
            end
            tick();
            drive_beats(exp_w, exp_w ? 4'd2 : 4'd1, 32'h0B00_0000 + 32'(r * 16));
            if (exp_w) m1_req = 1'b1; else m0_req = 1'b1;
            last_w = exp_w;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL rr_beats_left: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_addr_stall();
        logic [1:0] g;
        do_reset();
        raddr_ok = 1'b0; m0_req = 1'b1; m0_addr = 32'h400; m0_len = 4'd0;
        repeat (2) tick();
        m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h500; m1_len = 4'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            vectors++;
            if ({m0_gnt, m1_gnt, ren} !== 3'b000) begin
                miscompares++;
                $display("FAIL stall_idle cycle %0d: got gnt0=%b gnt1=%b ren=%b, expected 000", i, m0_gnt, m1_gnt, ren);
            end
            tick();
        end
        raddr_ok = 1'b1;
        await_any_gnt(1, g);
        vectors++;
        if (g !== 2'b10) begin
            miscompares++;
            $display("FAIL stall_grant: got gnt=%b, expected 10", g);
        end
        tick();
        m1_req = 1'b0; raddr_ok = 1'b0; rdata_ok = 1'b1; sram_rdata = 32'hBAD0;
        for (int i = 0; i < 2; i++) begin
            @(negedge ACLK);
            vectors++;
            if ({ren, araddr} !== {1'b1, 32'h500}) begin
                miscompares++;
                $display("FAIL stall_addr cycle %0d: got ren=%b araddr=%h, expected 1 500", i, ren, araddr);
            end
            tick();
        end
        raddr_ok = 1'b1; rdata_ok = 1'b0;
        tick();
        drive_beats(1'b1, 4'd2, 32'h0C00_0000);
        for (int i = 0; i < 2; i++) begin
            @(negedge ACLK);
            vectors++;
            if ({m0_gnt, m1_gnt} !== 2'b00) begin
                miscompares++;
                $display("FAIL dropped_req cycle %0d: got gnt=%b%b, expected 00", i, m1_gnt, m0_gnt);
            end
            tick();
        end
    endtask

    task automatic test_single_beat();
        logic [1:0] g;
        rdata_ok = 1'b1; sram_rdata = 32'h0BAD_0BAD;
        tick();
        rdata_ok = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h600; m1_len = 4'd0; raddr_ok = 1'b1;
        await_any_gnt(1, g);
        vectors++;
        if (g !== 2'b10) begin
            miscompares++;
            $display("FAIL len0_grant: got gnt=%b, expected 10", g);
        end
        tick();
        m1_req = 1'b0;
        tick();
        drive_beats(1'b1, 4'd0, 32'hDEAD_BEEF);
        @(negedge ACLK);
        vectors++;
        if ({sb.size() == 0, ren} !== 2'b10) begin
            miscompares++;
            $display("FAIL len0_done: got pending=%0d ren=%b, expected 0 0", sb.size(), ren);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        logic [1:0] g;
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h700; m0_len = 4'd3; raddr_ok = 1'b1;
        await_any_gnt(1, g);
        tick();
        m0_req = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            rdata_ok = 1'b1; sram_rdata = 32'h0D00_0000 + 32'(i);
            sb.push_back('{1'b0, 32'h0D00_0000 + 32'(i), 1'b0});
            @(negedge ACLK);
            tick();
        end
        ARESETn = 1'b0; sb.delete();
        tick();
        @(negedge ACLK);
        vectors++;
        if ({m0_gnt, m1_gnt, ren, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast, araddr, arlen, arsize, arid, rdata}
            !== 82'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got ren=%b rv=%b%b araddr=%h arlen=%h arsize=%h arid=%h rdata=%h, expected all 0",
                     ren, m1_rvalid, m0_rvalid, araddr, arlen, arsize, arid, rdata);
        end
        tick();
        ARESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            vectors++;
            if ({m0_rvalid, m1_rvalid, ren} !== 3'b000) begin
                miscompares++;
                $display("FAIL midreset_quiet cycle %0d: got rv0=%b rv1=%b ren=%b, expected 000", i, m0_rvalid, m1_rvalid, ren);
            end
            tick();
        end
        rdata_ok = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; m0_len = 4'd0; m1_len = 4'd0;
        await_any_gnt(1, g);
        vectors++;
`ifdef AXI_R_ARB_FIXED_PRIO_EN
        if (g !== 2'b10) begin
            miscompares++;
            $display("FAIL midreset_regrant: got gnt=%b, expected 10", g);
        end
`else
        if (g !== 2'b01) begin
            miscompares++;
            $display("FAIL midreset_regrant: got gnt=%b, expected 01", g);
        end
`endif
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        drive_beats(g[1], 4'd0, 32'h0E00_0000);
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL midreset_beats_left: got %0d pending, expected 0", sb.size());
        end
    endtask

    initial begin
        m0_req = 1'b0; m1_req = 1'b0; raddr_ok = 1'b0; rdata_ok = 1'b0;
        m0_addr = 32'h0; m1_addr = 32'h0; m0_len = 4'd0; m1_len = 4'd0; sram_rdata = 32'h0;
        ARESETn = 1'b0;
        test_reset();
        test_single_m0();
        test_round_robin();
        test_addr_stall();
        test_single_beat();
        test_reset_mid_burst();
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
